// File: rtl/prom_boot_pkg.sv
// Shared types and constants for the framed PROM boot loader.
package prom_boot_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    LO,
    HI,
    CSUM,
    RUN,
    ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/prom_boot_timeout.sv
// Inter-byte idle watchdog; built into prom_boot_ctrl only when PROM_BOOT_TIMEOUT_EN is defined.
module prom_boot_timeout
  import prom_boot_pkg::*;
#(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(CYCLES);

  logic [CW-1:0] cnt_q;

  // Down-counter reloads on clear; terminal count at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else if (clear_i) begin
      cnt_q <= LOAD;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired_o = enable_i && !clear_i && (cnt_q == '0);

endmodule

// File: rtl/prom_boot_ctrl.sv
// Framed PROM loader (SYNC, LEN, LEN x {LO,HI}, CSUM) that holds the CPU in reset until a frame verifies.
// Optional inter-byte timeout: define PROM_BOOT_TIMEOUT_EN.
//  state | meaning
//  HUNT  | waiting for first SYNC after reset
//  LEN   | expecting word count
//  LO/HI | expecting low / high byte of current word
//  CSUM  | expecting XOR checksum
//  RUN   | frame verified, CPU released
//  ERR   | frame rejected, waiting for SYNC
module prom_boot_ctrl
  import prom_boot_pkg::*;
#(
  parameter  int unsigned ROM_WORDS      = 27,
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned AW             = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_ready_i,
  output logic          rx_ack_o,
  output logic          prom_we_o,
  output logic [AW-1:0] prom_addr_o,
  output logic [15:0]   prom_data_o,
  output logic          cpu_reset_o,
  output logic          loaded_o,
  output logic          error_o
);

  localparam logic [7:0] MAX_LEN = 8'(ROM_WORDS);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] last_q;
  logic [7:0]    lo_q;
  logic [7:0]    csum_q;
  logic          we_q;
  logic [AW-1:0] paddr_q;
  logic [15:0]   pdata_q;
  logic          cpu_rst_q;
  logic          loaded_q;
  logic          error_q;

  logic is_sync;
  logic len_ok;
  logic tmo_expired;

  assign is_sync  = (rx_data_i == SYNC_BYTE);
  assign len_ok   = (rx_data_i != 8'd0) && (rx_data_i <= MAX_LEN);
  assign rx_ack_o = rx_ready_i;

`ifdef PROM_BOOT_TIMEOUT_EN
  logic mid_frame;
  assign mid_frame = (state_q == LEN) || (state_q == LO) ||
                     (state_q == HI)  || (state_q == CSUM);

  prom_boot_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (rx_ready_i || !mid_frame),
    .enable_i (mid_frame),
    .expired_o(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT;
      addr_q    <= '0;
      last_q    <= '0;
      lo_q      <= '0;
      csum_q    <= '0;
      we_q      <= 1'b0;
      paddr_q   <= '0;
      pdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      loaded_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (rx_ready_i) begin
        unique case (state_q)
          HUNT: begin
            if (is_sync) begin
              state_q <= LEN;
              error_q <= 1'b0;
              csum_q  <= '0;
            end
          end
          LEN: begin
            if (len_ok) begin
              state_q <= LO;
              // LEN <= ROM_WORDS, so LEN-1 always fits the address width.
              last_q  <= AW'(rx_data_i - 8'd1);
              addr_q  <= '0;
              csum_q  <= csum_q ^ rx_data_i;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
          LO: begin
            lo_q    <= rx_data_i;
            csum_q  <= csum_q ^ rx_data_i;
            state_q <= HI;
          end
          HI: begin
            we_q    <= 1'b1;
            paddr_q <= addr_q;
            pdata_q <= {rx_data_i, lo_q};
            csum_q  <= csum_q ^ rx_data_i;
            if (addr_q == last_q) begin
              state_q <= CSUM;
            end else begin
              addr_q  <= addr_q + AW'(1);
              state_q <= LO;
            end
          end
          CSUM: begin
            if (rx_data_i == csum_q) begin
              state_q   <= RUN;
              cpu_rst_q <= 1'b0;
              loaded_q  <= 1'b1;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
          RUN: begin
            if (is_sync) begin
              state_q   <= LEN;
              cpu_rst_q <= 1'b1;
              loaded_q  <= 1'b0;
              csum_q    <= '0;
            end
          end
          ERR: begin
            if (is_sync) begin
              state_q <= LEN;
              error_q <= 1'b0;
              csum_q  <= '0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end else if (tmo_expired) begin
        state_q <= ERR;
        error_q <= 1'b1;
      end
    end
  end

  assign prom_we_o   = we_q;
  assign prom_addr_o = paddr_q;
  assign prom_data_o = pdata_q;
  assign cpu_reset_o = cpu_rst_q;
  assign loaded_o    = loaded_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_prom_boot_ctrl.sv
// Scoreboard bench for prom_boot_ctrl: expected PROM writes queued by stimulus, checked by a monitor.
module tb_prom_boot_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_ack_o;
  logic        prom_we_o;
  logic [4:0]  prom_addr_o;
  logic [15:0] prom_data_o;
  logic        cpu_reset_o;
  logic        loaded_o;
  logic        error_o;

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        prev_we = 1'b0;
  logic [15:0] wbuf [27];

  prom_boot_ctrl #(
    .ROM_WORDS     (27),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data_i  (rx_data),
    .rx_ready_i (rx_ready),
    .rx_ack_o   (rx_ack_o),
    .prom_we_o  (prom_we_o),
    .prom_addr_o(prom_addr_o),
    .prom_data_o(prom_data_o),
    .cpu_reset_o(cpu_reset_o),
    .loaded_o   (loaded_o),
    .error_o    (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (prom_we_o) begin
      chk("we_pulse_width", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {27'd0, prom_addr_o}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, prom_addr_o}, {27'd0, e.a});
        chk("wr_data", {16'd0, prom_data_o}, {16'd0, e.d});
      end
    end
    prev_we = prom_we_o;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    #1 chk("rx_ack", {31'd0, rx_ack_o}, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic push(input logic [4:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_status(input string tag, input logic rst, input logic ld, input logic er);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset_o}, {31'd0, rst});
    chk({tag, "_loaded"},    {31'd0, loaded_o},    {31'd0, ld});
    chk({tag, "_error"},     {31'd0, error_o},     {31'd0, er});
  endtask

  // Sends a full frame of n words from wbuf with a correct checksum.
  task automatic load_frame(input int n);
    logic [7:0] cs;
    cs = 8'(n);
    send(8'hA5);
    send(8'(n));
    for (int i = 0; i < n; i++) begin
      send(wbuf[i][7:0]);
      send(wbuf[i][15:8]);
      cs = cs ^ wbuf[i][7:0] ^ wbuf[i][15:8];
      push(5'(i), wbuf[i]);
    end
    send(cs);
  endtask

  initial begin
    reset    = 1'b1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_status("reset", 1'b1, 1'b0, 1'b0);
    chk("reset_we",   {31'd0, prom_we_o},   32'd0);
    chk("reset_addr", {27'd0, prom_addr_o}, 32'd0);
    chk("reset_data", {16'd0, prom_data_o}, 32'd0);

    // Test 1: basic two-word frame
    push(5'd0, 16'h1234);
    push(5'd1, 16'h5678);
    send(8'hA5); send(8'h02); send(8'h34); send(8'h12);
    send(8'h78); send(8'h56);
    send(8'h0A);
    idle();
    chk_status("t1", 1'b0, 1'b1, 1'b0);

    // Test 2: bad checksum then good frame
    push(5'd0, 16'h1234);
    push(5'd1, 16'h5678);
    send(8'hA5); send(8'h02); send(8'h34); send(8'h12);
    send(8'h78); send(8'h56); send(8'h0B);
    idle();
    chk_status("t2_bad", 1'b1, 1'b0, 1'b1);
    push(5'd0, 16'h1234);
    push(5'd1, 16'h5678);
    send(8'hA5); send(8'h02); send(8'h34); send(8'h12);
    send(8'h78); send(8'h56); send(8'h0A);
    idle();
    chk_status("t2_good", 1'b0, 1'b1, 1'b0);

    // Test 3: illegal lengths 0 and 28
    send(8'hA5); send(8'h00);
    idle();
    chk_status("t3_len0", 1'b1, 1'b0, 1'b1);
    send(8'hA5);
    idle();
    chk("t3_sync_clears_err", {31'd0, error_o}, 32'd0);
    send(8'h1C);
    idle();
    chk_status("t3_len28", 1'b1, 1'b0, 1'b1);

    // Max-length frame: top address 26
    for (int i = 0; i < 27; i++) wbuf[i] = {8'(i + 8'h30), 8'(i ^ 8'h5A)};
    load_frame(27);
    idle();
    chk_status("max_len", 1'b0, 1'b1, 1'b0);

    // Test 4: 0xA5 inside payload is data
    push(5'd0, 16'hA5A5);
    send(8'hA5); send(8'h01); send(8'hA5); send(8'hA5); send(8'h01);
    idle();
    chk_status("t4", 1'b0, 1'b1, 1'b0);

    // Test 5: RUN ignores non-sync, sync re-enters LEN
    send(8'h11);
    idle();
    chk_status("t5_ignore", 1'b0, 1'b1, 1'b0);
    send(8'hA5);
    idle();
    chk_status("t5_sync", 1'b1, 1'b0, 1'b0);
    push(5'd0, 16'h1234);
    send(8'h01); send(8'h34); send(8'h12); send(8'h27);
    idle();
    chk_status("t5_reload", 1'b0, 1'b1, 1'b0);

    // Test 6: reset mid-frame, byte presented during reset is dropped
    send(8'hA5); send(8'h01); send(8'h34);
    @(negedge clk);
    reset    = 1'b1;
    rx_ready = 1'b1;
    rx_data  = 8'hA5;
    #1 chk("t6_ack_in_reset", {31'd0, rx_ack_o}, 32'd1);
    @(negedge clk);
    reset    = 1'b0;
    rx_ready = 1'b0;
    chk_status("t6_reset", 1'b1, 1'b0, 1'b0);
    chk("t6_addr", {27'd0, prom_addr_o}, 32'd0);
    chk("t6_data", {16'd0, prom_data_o}, 32'd0);
    send(8'h01); send(8'h34); send(8'h12); send(8'h27);
    idle();
    chk_status("t6_hunt", 1'b1, 1'b0, 1'b0);

`ifdef PROM_BOOT_TIMEOUT_EN
    send(8'hA5); send(8'h01);
    idle();
    repeat (1100) @(negedge clk);
    chk_status("timeout", 1'b1, 1'b0, 1'b1);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
